// File: rtl/rv32i_prefetch_ifu.sv
// RV32I instruction prefetch unit: single-outstanding fetcher feeding a DEPTH-entry
// {pc,instr} queue, with redirect flush and a DISCARD state that swallows stale acks.
module rv32i_prefetch_ifu #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        RN,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fpc;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          run;

  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_instr [DEPTH];

  logic pop;
  logic ack;
  logic push;
  logic can_issue;

  assign dec_valid = (count != '0);
  assign dec_pc    = q_pc[rd_ptr];
  assign dec_instr = q_instr[rd_ptr];

  assign pop  = dec_valid & dec_ready;
  // An ack only means something while a request is actually outstanding.
  assign ack  = imem_ack & imem_req;
  assign push = (state == S_WAIT) & ack & ~redirect_valid;

  // In IDLE nothing is in flight, so only the pop can change occupancy this cycle.
  assign can_issue = run & ((count - CW'(pop)) < FULL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state     <= S_IDLE;
      fpc       <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      run       <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      // run delays the first request to the second edge after reset release.
      run <= 1'b1;
      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        fpc    <= redirect_pc & ~32'h3;
        case (state)
          S_WAIT: begin
            if (ack) begin
              imem_req <= 1'b0;
              state    <= S_IDLE;
            end else begin
              state <= S_DISCARD;
            end
          end
          S_DISCARD: begin
            if (ack) begin
              imem_req <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else begin
        case (state)
          S_IDLE: begin
            if (can_issue) begin
              imem_req  <= 1'b1;
              imem_addr <= fpc;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (ack) begin
              fpc      <= fpc + 32'd4;
              imem_req <= 1'b0;
              state    <= S_IDLE;
            end
          end
          S_DISCARD: begin
            if (ack) begin
              imem_req <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
        count  <= count + CW'(push) - CW'(pop);
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count gates dec_valid, so stale
  // contents are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fpc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_rv32i_prefetch_ifu.sv
// Self-checking bench for rv32i_prefetch_ifu: directed scenarios plus random traffic,
// all compared against a transaction-level queue model of the fetch stream.
module tb_rv32i_prefetch_ifu;

  localparam int          DEPTH = 4;
  localparam logic [31:0] W_PC  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rn  = 1'b1;
  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dec_valid, w_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr, dec_pc, w_instr, w_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  rv32i_prefetch_ifu #(.DEPTH(DEPTH)) dut (
    .clk(clk), .RN(rn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Second instance shares every input; only its start address differs.
  rv32i_prefetch_ifu #(.DEPTH(DEPTH), .RESET_PC(W_PC)) dut_w (
    .clk(clk), .RN(rn), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dec_valid(w_valid),
    .dec_ready(dec_ready), .dec_instr(w_instr), .dec_pc(w_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: expected queue of pcs, fetch pointer and outstanding request.
  logic [31:0] m_q[$];
  logic [31:0] m_fpc, m_addr;
  bit          m_out, m_disc, m_run;

  logic [31:0] fetched[$], fetched_w[$], popped[$];
  bit          prev_req, prev_wreq;
  int          mem_dly, dly;
  bit          busy, spur_en, release_now, w_chk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc  = 32'h0;
    m_addr = 32'h0;
    m_out  = 1'b0;
    m_disc = 1'b0;
    m_run  = 1'b0;
  endtask

  // One clock edge of the fetch-stream rules: flush on redirect, else pop, take the
  // returned word (unless it belongs to a flushed stream), or start a new fetch.
  task automatic model_step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit a);
    bit pop, ak, was_run;
    pop     = (m_q.size() != 0) && rdy;
    ak      = a && m_out;
    was_run = m_run;
    m_run   = 1'b1;
    if (redir) begin
      m_q.delete();
      m_fpc = rpc & ~32'h3;
      if (m_out && ak) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end else if (m_out) begin
        m_disc = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (ak) begin
        if (!m_disc) begin
          m_q.push_back(m_fpc);
          m_fpc = m_fpc + 32'd4;
        end
        m_out  = 1'b0;
        m_disc = 1'b0;
      end else if (!m_out && was_run && m_q.size() < DEPTH) begin
        m_out  = 1'b1;
        m_addr = m_fpc;
      end
    end
  endtask

  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    dec_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        dly  = (mem_dly < 0) ? int'($urandom_range(0, 3)) : mem_dly;
      end
      if (dly == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        dly--;
      end
    end else begin
      busy       = 1'b0;
      imem_ack   = spur_en && ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom;
    end
    if (release_now) begin
      rn          = 1'b1;
      release_now = 1'b0;
    end
    if (imem_req && !prev_req) fetched.push_back(imem_addr);
    if (w_req && !prev_wreq) fetched_w.push_back(w_addr);
    prev_req  = imem_req;
    prev_wreq = w_req;
    if (dec_valid && rdy) popped.push_back(dec_pc);

    check("req", imem_req, m_out);
    if (m_out) check("addr", imem_addr, m_addr);
    check("valid", dec_valid, m_q.size() != 0);
    check("w_valid", w_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("pc", dec_pc, m_q[0]);
      check("instr", dec_instr, mem_word(m_q[0]));
      if (w_chk) begin
        check("w_pc", w_pc, W_PC + m_q[0]);
        check("w_instr", w_instr, mem_word(m_q[0]));
      end
    end
    if (rn) model_step(rdy, redir, rpc, imem_ack);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, then releases it.
  task automatic do_reset();
    #2 rn = 1'b0;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", dec_valid, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_waddr", w_addr, W_PC);
    model_reset();
    fetched.delete();
    fetched_w.delete();
    popped.delete();
    busy     = 1'b0;
    imem_ack = 1'b0;
    cycle(0, 0, 32'h0);
    cycle(0, 0, 32'h0);
    release_now = 1'b1;
    cycle(0, 0, 32'h0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 12 && !imem_req; i++) cycle(0, 0, 32'h0);
    check("req_seen", imem_req, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    model_reset();
    mem_dly = 0;
    spur_en = 1'b0;

    // Streaming: one fetch per two cycles, both instances.
    w_chk = 1'b1;
    do_reset();
    repeat (16) cycle(1, 0, 32'h0);
    check("seq_a0", qget(fetched, 0), 32'h0);
    check("seq_a1", qget(fetched, 1), 32'h4);
    check("seq_a2", qget(fetched, 2), 32'h8);
    check("seq_a3", qget(fetched, 3), 32'hC);
    check("seq_p0", qget(popped, 0), 32'h0);
    check("seq_p1", qget(popped, 1), 32'h4);
    check("seq_p2", qget(popped, 2), 32'h8);
    check("wrap_a0", qget(fetched_w, 0), 32'hFFFF_FFF8);
    check("wrap_a1", qget(fetched_w, 1), 32'hFFFF_FFFC);
    check("wrap_a2", qget(fetched_w, 2), 32'h0000_0000);
    w_chk = 1'b0;

    // Backpressure: queue fills, fetching stops, resumes at 0x10.
    do_reset();
    repeat (24) cycle(0, 0, 32'h0);
    check("full_n", fetched.size(), 4);
    check("full_a3", qget(fetched, 3), 32'hC);
    check("full_req", imem_req, 1'b0);
    check("full_valid", dec_valid, 1'b1);
    check("full_pc", dec_pc, 32'h0);
    for (int i = 0; i < 20 && fetched.size() < 5; i++) cycle(1, 0, 32'h0);
    check("resume_a", qget(fetched, 4), 32'h10);

    // Redirect while a slow fetch is outstanding.
    mem_dly = 3;
    do_reset();
    wait_req();
    cycle(0, 1, 32'h0000_0066);
    cycle(1, 0, 32'h0);
    check("disc_valid", dec_valid, 1'b0);
    check("disc_req", imem_req, 1'b1);
    for (int i = 0; i < 20 && fetched.size() < 2; i++) cycle(1, 0, 32'h0);
    check("redir_a", qget(fetched, 1), 32'h64);
    for (int i = 0; i < 20 && popped.size() < 1; i++) cycle(1, 0, 32'h0);
    check("redir_pc", qget(popped, 0), 32'h64);

    // Two redirects inside DISCARD: only the last target is fetched.
    do_reset();
    wait_req();
    cycle(1, 1, 32'h40);
    cycle(1, 1, 32'h80);
    for (int i = 0; i < 20 && fetched.size() < 2; i++) cycle(1, 0, 32'h0);
    check("redir2_a", qget(fetched, 1), 32'h80);
    found = 1'b0;
    foreach (fetched[i]) if (fetched[i] == 32'h40) found = 1'b1;
    check("no_0x40", found, 1'b0);

    // Random traffic: variable latency, stray acks, random stalls and redirects.
    mem_dly = -1;
    spur_en = 1'b1;
    do_reset();
    repeat (2000) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);

    // Reset in the middle of a fetch with three entries queued.
    spur_en = 1'b0;
    mem_dly = 3;
    do_reset();
    for (int i = 0; i < 60 && !(m_q.size() == 3 && imem_req); i++) cycle(0, 0, 32'h0);
    check("pre_rst_cnt", m_q.size(), 3);
    check("pre_rst_valid", dec_valid, 1'b1);
    spur_en = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && fetched.size() < 1; i++) cycle(1, 0, 32'h0);
    check("refetch_a", qget(fetched, 0), 32'h0);
    repeat (20) cycle(1, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
